// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter/rotator with valid/ready handshakes on both sides.
// Each SHIFT cycle moves the operand by at most STEP bits until the requested distance is consumed.
module seq_shift_unit #(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    parameter int SW_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [SW_W-1:0]  in_shamt,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_err,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [2:0] OP_SLL  = 3'b000;
    localparam logic [2:0] OP_SRL  = 3'b001;
    localparam logic [2:0] OP_PASS = 3'b010;
    localparam logic [2:0] OP_SRA  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;

    // One extra bit so STEP == WIDTH is representable in the comparison.
    localparam logic [SW_W:0] STEP_W = (SW_W+1)'(STEP);

    state_t           state_reg;
    logic [WIDTH-1:0] data_reg;
    logic [2:0]       op_reg;
    logic [SW_W-1:0]  rem_reg;
    logic             err_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic             busy_reg;

    logic [SW_W:0]    step_amt;
    logic [SW_W-1:0]  s_amt;
    logic [SW_W-1:0]  rem_next;
    logic [WIDTH-1:0] rol_bits;
    logic [WIDTH-1:0] ror_bits;
    logic [WIDTH-1:0] step_next;

    always_comb begin
        step_amt = ({1'b0, rem_reg} > STEP_W) ? STEP_W : {1'b0, rem_reg};
        s_amt    = step_amt[SW_W-1:0];
        rem_next = rem_reg - s_amt;
    end

    // Rotations index modulo WIDTH, which the SW_W-bit wraparound gives for free.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_rot
            assign rol_bits[gi] = data_reg[SW_W'(gi) - s_amt];
            assign ror_bits[gi] = data_reg[SW_W'(gi) + s_amt];
        end
    endgenerate

    always_comb begin
        step_next = data_reg;
        case (op_reg)
            OP_SLL:  step_next = data_reg << s_amt;
            OP_SRL:  step_next = data_reg >> s_amt;
            OP_SRA:  step_next = $unsigned($signed(data_reg) >>> s_amt);
            OP_ROL:  step_next = rol_bits;
            OP_ROR:  step_next = ror_bits;
            default: step_next = data_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            data_reg      <= '0;
            op_reg        <= OP_SLL;
            rem_reg       <= '0;
            err_reg       <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        data_reg     <= in_a;
                        op_reg       <= in_op;
                        err_reg      <= in_op[2] & in_op[1];
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        if (in_shamt == '0 || in_op == OP_PASS || (in_op[2] & in_op[1])) begin
                            rem_reg       <= '0;
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b1;
                        end else begin
                            rem_reg   <= in_shamt;
                            state_reg <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    data_reg <= step_next;
                    rem_reg  <= rem_next;
                    if (rem_next == '0) begin
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign out_y     = data_reg;
    assign out_err   = err_reg;
endmodule

// File: tb/tb_seq_shift_unit.sv
// Scoreboard bench for seq_shift_unit: one STEP=1 and one STEP=4 instance sharing clock, reset and data inputs.
module tb_seq_shift_unit;
    localparam logic [2:0] SLL = 3'b000, SRL = 3'b001, PASS = 3'b010,
                           SRA = 3'b011, ROL = 3'b100, ROR = 3'b101;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_a;
    logic [3:0]  in_shamt;
    logic [2:0]  in_op;
    logic        in_valid_v [2];
    logic        out_ready_v[2];
    logic        in_ready_v [2];
    logic        out_valid_v[2];
    logic        out_err_v  [2];
    logic        busy_v     [2];
    logic [15:0] out_y_v    [2];

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] y;
        logic        err;
        int          lat;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    logic acc_pend[2];
    int   cnt[2];
    bit   counting[2];
    bit   seen[2];

    always #5 clk = ~clk;

    seq_shift_unit #(.WIDTH(16), .STEP(1)) u_dut_s1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .in_a(in_a), .in_shamt(in_shamt), .in_op(in_op),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .out_y(out_y_v[0]), .out_err(out_err_v[0]), .busy(busy_v[0])
    );

    seq_shift_unit #(.WIDTH(16), .STEP(4)) u_dut_s4 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .in_a(in_a), .in_shamt(in_shamt), .in_op(in_op),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .out_y(out_y_v[1]), .out_err(out_err_v[1]), .busy(busy_v[1])
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic mon_compare(int d);
        exp_t e;
        bit   have;
        have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
        check($sformatf("dut%0d_unexpected_out_valid", d), 32'(have), 32'd1);
        if (have) begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            $display("result dut%0d y=0x%04h err=%0d lat=%0d (exp y=0x%04h err=%0d lat=%0d)",
                     d, out_y_v[d], out_err_v[d], counting[d] ? cnt[d] : -1, e.y, e.err, e.lat);
            check($sformatf("dut%0d_out_y", d), 32'(out_y_v[d]), 32'(e.y));
            check($sformatf("dut%0d_out_err", d), 32'(out_err_v[d]), 32'(e.err));
            check($sformatf("dut%0d_latency", d), counting[d] ? cnt[d] : -1, e.lat);
        end
    endtask

    // Acceptance is decided by values stable just before the coming rising edge.
    initial begin
        for (int d = 0; d < 2; d++) acc_pend[d] = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            for (int d = 0; d < 2; d++)
                acc_pend[d] = in_valid_v[d] && in_ready_v[d] && !reset;
        end
    end

    // Monitor: counts edges from acceptance and pops on each rising out_valid.
    initial begin
        for (int d = 0; d < 2; d++) begin
            cnt[d] = 0; counting[d] = 0; seen[d] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (reset) begin
                    counting[d] = 0;
                    seen[d]     = 0;
                end else begin
                    if (acc_pend[d]) begin
                        cnt[d] = 1;
                        counting[d] = 1;
                    end else if (counting[d]) begin
                        cnt[d]++;
                    end
                    if (out_valid_v[d] && !seen[d]) begin
                        seen[d] = 1;
                        mon_compare(d);
                        counting[d] = 0;
                    end else if (!out_valid_v[d]) begin
                        seen[d] = 0;
                    end
                end
            end
        end
    end

    task automatic issue(int d, logic [2:0] op, logic [15:0] a, logic [3:0] sh,
                         logic [15:0] ey, logic ee, int lat);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!in_ready_v[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("dut%0d_ready_wait", d), 32'(in_ready_v[d]), 32'd1);
        e.y = ey; e.err = ee; e.lat = lat;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        in_a = a; in_shamt = sh; in_op = op; in_valid_v[d] = 1'b1;
        @(negedge clk);
        // Scramble the shared inputs so any late sampling shows up in the result.
        in_valid_v[d] = 1'b0; in_a = ~a; in_shamt = ~sh; in_op = SRL;
    endtask

    task automatic wait_idle(int d);
        int n = 0;
        while (!in_ready_v[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("dut%0d_idle_wait", d), 32'(in_ready_v[d]), 32'd1);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        in_a = '0; in_shamt = '0; in_op = '0;
        for (int d = 0; d < 2; d++) begin
            in_valid_v[d] = 1'b0;
            out_ready_v[d] = 1'b1;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d_rst_in_ready", d), 32'(in_ready_v[d]), 32'd1);
            check($sformatf("dut%0d_rst_out_valid", d), 32'(out_valid_v[d]), 32'd0);
            check($sformatf("dut%0d_rst_busy", d), 32'(busy_v[d]), 32'd0);
            check($sformatf("dut%0d_rst_out_y", d), 32'(out_y_v[d]), 32'd0);
            check($sformatf("dut%0d_rst_out_err", d), 32'(out_err_v[d]), 32'd0);
        end

        issue(0, SLL,    16'h00B6, 4'd3,  16'h05B0, 1'b0, 4);
        issue(0, SRA,    16'hB600, 4'd4,  16'hFB60, 1'b0, 5);
        issue(0, SRL,    16'hB600, 4'd4,  16'h0B60, 1'b0, 5);
        issue(0, ROL,    16'h8001, 4'd1,  16'h0003, 1'b0, 2);
        issue(0, ROR,    16'h8001, 4'd15, 16'h0003, 1'b0, 16);
        issue(0, PASS,   16'hA5A5, 4'd9,  16'hA5A5, 1'b0, 1);
        issue(0, 3'b111, 16'h1234, 4'd5,  16'h1234, 1'b1, 1);
        issue(0, 3'b110, 16'h00F0, 4'd2,  16'h00F0, 1'b1, 1);
        issue(0, ROR,    16'h1234, 4'd0,  16'h1234, 1'b0, 1);
        issue(0, SLL,    16'hFFFF, 4'd15, 16'h8000, 1'b0, 16);
        wait_idle(0);

        issue(1, ROR,    16'h1234, 4'd7,  16'h6824, 1'b0, 3);
        issue(1, SRA,    16'h8000, 4'd15, 16'hFFFF, 1'b0, 5);
        issue(1, SLL,    16'h0001, 4'd15, 16'h8000, 1'b0, 5);
        issue(1, ROL,    16'h8421, 4'd4,  16'h4218, 1'b0, 2);
        issue(1, SRL,    16'hF000, 4'd8,  16'h00F0, 1'b0, 3);
        issue(1, 3'b110, 16'hBEEF, 4'd3,  16'hBEEF, 1'b1, 1);
        issue(1, SLL,    16'h0F0F, 4'd4,  16'hF0F0, 1'b0, 2);
        wait_idle(1);

        // Backpressure: result must hold and stray requests must be ignored.
        out_ready_v[0] = 1'b0;
        issue(0, SLL, 16'h0001, 4'd2, 16'h0004, 1'b0, 3);
        n = 0;
        while (!out_valid_v[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", 32'(out_valid_v[0]), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_y", 32'(out_y_v[0]), 32'h0004);
            check("bp_hold_valid", 32'(out_valid_v[0]), 32'd1);
            check("bp_in_ready", 32'(in_ready_v[0]), 32'd0);
            if (i == 1) begin
                in_valid_v[0] = 1'b1; in_a = 16'hFFFF; in_op = SLL; in_shamt = 4'd1;
            end else begin
                in_valid_v[0] = 1'b0;
            end
            @(negedge clk);
        end
        in_valid_v[0] = 1'b0;
        out_ready_v[0] = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 32'(in_ready_v[0]), 32'd1);
        check("bp_release_out_valid", 32'(out_valid_v[0]), 32'd0);

        // Reset during the 4th SHIFT cycle of a 10-step shift; no result may appear.
        @(negedge clk);
        in_a = 16'hFFFF; in_shamt = 4'd10; in_op = SLL; in_valid_v[0] = 1'b1;
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy_before_reset", 32'(busy_v[0]), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_in_ready", 32'(in_ready_v[0]), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid_v[0]), 32'd0);
        check("mid_rst_busy", 32'(busy_v[0]), 32'd0);
        check("mid_rst_out_y", 32'(out_y_v[0]), 32'd0);

        // Reset together with in_valid: the request must not be taken.
        @(negedge clk);
        reset = 1'b1; in_valid_v[0] = 1'b1; in_a = 16'h5555; in_op = PASS; in_shamt = 4'd0;
        @(negedge clk);
        reset = 1'b0; in_valid_v[0] = 1'b0;
        check("rst_wins_busy", 32'(busy_v[0]), 32'd0);
        @(negedge clk);
        check("rst_wins_out_valid", 32'(out_valid_v[0]), 32'd0);

        issue(0, SLL, 16'h0003, 4'd4, 16'h0030, 1'b0, 5);
        wait_idle(0);
        wait_idle(1);
        repeat (3) @(negedge clk);
        check("dut0_queue_drained", q0.size(), 32'd0);
        check("dut1_queue_drained", q1.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
- Parametrised multi-cycle shifter/rotator. Next generation of the combinational 4-mode barrel shifter.
- Adds rotate modes, configurable data width and a bits-per-cycle step size.
- Uses a valid/ready handshake on both input and output, so it can sit between register-file read and write-back, or behind switch/LED test wrappers on the board.
- Trades latency for area: each cycle shifts by at most STEP bits.

Parameters:
- WIDTH, 16, data width in bits; power of two, at least 4.
- STEP, 1, maximum shift distance applied per clock; power of two, 1..WIDTH.
- SW_W, $clog2(WIDTH), width of the shift-amount field (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request.
- in_a  in  WIDTH  operand.
- in_shamt  in  SW_W  shift distance, 0..WIDTH-1.
- in_op  in  3  operation: 000 SLL, 001 SRL, 010 PASS, 011 SRA, 100 ROL, 101 ROR, 110/111 illegal.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_y  out  WIDTH  result.
- out_err  out  1  result came from an illegal opcode; qualified by out_valid.
- busy  out  1  high in SHIFT or DONE.

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values:
  - State = IDLE.
  - in_ready = 1, out_valid = 0, busy = 0.
  - out_y = 0, out_err = 0.
  - Internal remaining-count register = 0.
- States:
  - IDLE: in_ready = 1.
    - Acceptance = in_valid & in_ready at a rising edge. It captures in_a into the data register, plus in_op and in_shamt.
    - Define k = ceil(in_shamt/STEP).
    - If k = 0, or op is PASS, or op is illegal: go to DONE.
    - Otherwise go to SHIFT, with rem = in_shamt.
  - SHIFT: in_ready = 0.
    - Each edge, let s = min(rem, STEP) and apply one step of distance s:
      - SLL: zero fill at the LSB.
      - SRL: zero fill at the MSB.
      - SRA: fill with the current MSB; the sign is preserved across steps.
      - ROL/ROR: bits wrap around.
    - rem <= rem - s. When rem - s = 0, go to DONE on the same edge.
  - DONE: out_valid = 1; out_y and out_err are held stable.
    - On out_valid & out_ready at an edge, go to IDLE.
    - There is no IDLE bypass. The next request can be accepted one cycle after the output handshake, so throughput is at most one result per 2+k cycles.
- Latency:
  - out_valid first asserts in the cycle that begins 1+k edges after the acceptance edge.
  - Latency is independent of out_ready.
- Result values:
  - out_y equals the single-step combinational result of the op applied to the captured operand by the full in_shamt.
  - PASS and illegal ops return the operand unchanged.
  - out_err = 1 only for op 110/111.
- Arithmetic and widths:
  - All operations stay within WIDTH bits; there is no carry-out.
  - in_shamt cannot express a distance of WIDTH or more.
  - Rotating by 0 returns the operand.
- Boundary conditions:
  - in_valid while not IDLE: ignored, not captured, not queued. The requester must hold its request until in_ready.
  - out_ready high while out_valid is low: no effect.
  - out_ready held high continuously: DONE lasts exactly one cycle.
  - Inputs changing during SHIFT or DONE: no effect on the result.
  - Reset in any state, including mid-SHIFT or DONE with out_ready low: next cycle is IDLE with reset output values. The in-flight result is discarded and out_valid is never raised for it.
  - Reset and in_valid asserted together: reset wins; the request is not accepted.
  - STEP = WIDTH: every non-zero shift completes in one SHIFT cycle (latency 2).

Test Plan:
- WIDTH=16, STEP=1: SLL of 0x00B6 by 3 -> out_y=0x05B0, out_err=0. out_valid asserts 4 cycles after acceptance.
- SRA of 0xB600 by 4 -> 0xFB60. SRL of 0xB600 by 4 -> 0x0B60. Each has latency 5.
- ROL of 0x8001 by 1 -> 0x0003. ROR of 0x8001 by 15 -> 0x0003.
- STEP=4: ROR of 0x1234 by 7 -> 0x6824 with latency 3.
- PASS of 0xA5A5 by 9 -> 0xA5A5 with latency 1. Op 111 on 0x1234 -> out_y=0x1234, out_err=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Check out_y is stable and in_ready=0. Pulse in_valid with other data during the hold and check it is ignored. Release out_ready; check in_ready=1 on the next cycle.
- Reset mid-operation: SLL of 0xFFFF by 10 with STEP=1; assert reset in the 4th SHIFT cycle -> IDLE next cycle, out_valid never high. A new request then completes correctly.
